// File: rtl/multiport_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// multiport_ram_arbiter_pkg
// Definitions shared by the multiport RAM and its requester arbiter:
//   - default geometry of the RAM (address width, word width, port count)
//   - slice_lsb(): LSB position of slice idx inside a packed bus whose slices
//     are width bits wide (slice idx occupies [(idx+1)*width-1 -: width]).
// No ports; this is a package.
// ---------------------------------------------------------------------------
package multiport_ram_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_MEM_WIDTH  = 12;
    localparam int DEFAULT_PORT_COUNT = 2;

    // Low bit of slice idx in a packed bus; use with "+: width".
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/multiport_ram_arbiter_rr_port_allocator.sv
// ---------------------------------------------------------------------------
// rr_port_allocator
// Purely combinational round-robin allocation of RAM ports to requesters.
// Requesters are scanned starting at rr_ptr, wrapping modulo NUM_REQ. Each
// eligible requester takes the next free port (port 0 first). A requester is
// skipped when its address matches one already granted in this scan and
// either access is a write, so the RAM never sees a same-cycle write race.
// Ports:
//   req_valid/req_we  in  per-requester pending flag and write flag
//   req_addr          in  packed requester addresses
//   rr_ptr            in  first requester to scan this cycle
//   grant             out one bit per requester granted this cycle
//   port_valid        out one bit per RAM port in use
//   port_id           out requester that owns each port
//   next_ptr          out one past the last granted requester, else rr_ptr
// ---------------------------------------------------------------------------
module rr_port_allocator
    import multiport_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int PORT_COUNT = DEFAULT_PORT_COUNT,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int PTR_WIDTH  = 2
) (
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [PTR_WIDTH-1:0]          rr_ptr,
    output logic [NUM_REQ-1:0]            grant,
    output logic [PORT_COUNT-1:0]         port_valid,
    output logic [PTR_WIDTH-1:0]          port_id [PORT_COUNT],
    output logic [PTR_WIDTH-1:0]          next_ptr
);

    logic [PTR_WIDTH-1:0]  scan_s;
    logic [ADDR_WIDTH-1:0] cand_addr_s;
    logic [ADDR_WIDTH-1:0] taken_addr_s [PORT_COUNT];
    logic [PORT_COUNT-1:0] taken_we_s;
    logic                  hazard_s;
    logic                  placed_s;

    // Walk the requesters once in round-robin order and fill ports in order.
    always_comb begin
        grant       = '0;
        port_valid  = '0;
        next_ptr    = rr_ptr;
        scan_s      = rr_ptr;
        cand_addr_s = '0;
        taken_we_s  = '0;
        hazard_s    = 1'b0;
        placed_s    = 1'b0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            port_id[p]      = '0;
            taken_addr_s[p] = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_addr_s = req_addr[slice_lsb(int'(scan_s), ADDR_WIDTH) +: ADDR_WIDTH];
            // Only read/read sharing of an address is allowed within one cycle.
            hazard_s = 1'b0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                hazard_s = hazard_s | (port_valid[p] & (taken_addr_s[p] == cand_addr_s)
                                       & (taken_we_s[p] | req_we[scan_s]));
            end
            placed_s = 1'b0;
            if (req_valid[scan_s] && !hazard_s) begin
                // Ports are filled in order, so the first free one is the next one.
                for (int p = 0; p < PORT_COUNT; p++) begin
                    if (!placed_s && !port_valid[p]) begin
                        port_valid[p]   = 1'b1;
                        port_id[p]      = scan_s;
                        taken_addr_s[p] = cand_addr_s;
                        taken_we_s[p]   = req_we[scan_s];
                        grant[scan_s]   = 1'b1;
                        placed_s        = 1'b1;
                        next_ptr        = (scan_s == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : scan_s + 1'b1;
                    end else begin
                        placed_s = placed_s;
                    end
                end
            end else begin
                placed_s = 1'b0;
            end
            scan_s = (scan_s == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : scan_s + 1'b1;
        end
    end

endmodule

// File: rtl/multiport_ram_arbiter.sv
// ---------------------------------------------------------------------------
// multiport_ram_arbiter
// Shares the PORT_COUNT ports of a multiport RAM between NUM_REQ requesters.
// Grants are combinational (req_ready); the RAM registers its read data, so
// the owner of each port is remembered for one cycle and the RAM output is
// routed back to it (rsp_valid/rsp_data, one cycle after req_ready). Writes
// are acknowledged with the written word read back by the RAM.
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   req_valid/req_we/req_addr/req_wdata  requester side, packed per requester
//   req_ready                    grant, request accepted this cycle
//   rsp_valid/rsp_data           response, packed per requester
//   ram_address/ram_datain/ram_mem_write  RAM side, packed per port
//   ram_dataout                  registered RAM read data, packed per port
// ---------------------------------------------------------------------------
module multiport_ram_arbiter
    import multiport_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int PORT_COUNT = DEFAULT_PORT_COUNT,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MEM_WIDTH  = DEFAULT_MEM_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*MEM_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [NUM_REQ*MEM_WIDTH-1:0]    rsp_data,
    output logic [PORT_COUNT*ADDR_WIDTH-1:0] ram_address,
    output logic [PORT_COUNT*MEM_WIDTH-1:0] ram_datain,
    output logic [PORT_COUNT-1:0]           ram_mem_write,
    input  logic [PORT_COUNT*MEM_WIDTH-1:0] ram_dataout
);

    localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_WIDTH-1:0]  rr_ptr_r;
    logic [PORT_COUNT-1:0] own_valid_r;
    logic [PTR_WIDTH-1:0]  own_id_r [PORT_COUNT];

    logic [NUM_REQ-1:0]    alloc_grant_s;
    logic [PORT_COUNT-1:0] alloc_port_valid_s;
    logic [PTR_WIDTH-1:0]  alloc_port_id_s [PORT_COUNT];
    logic [PTR_WIDTH-1:0]  alloc_next_ptr_s;

    rr_port_allocator #(
        .NUM_REQ    (NUM_REQ),
        .PORT_COUNT (PORT_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_alloc (
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .rr_ptr     (rr_ptr_r),
        .grant      (alloc_grant_s),
        .port_valid (alloc_port_valid_s),
        .port_id    (alloc_port_id_s),
        .next_ptr   (alloc_next_ptr_s)
    );

    // Grants are suppressed while reset is held.
    always_comb begin
        req_ready = reset ? '0 : alloc_grant_s;
    end

    // Round-robin pointer and per-port ownership for the response cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r    <= '0;
            own_valid_r <= '0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                own_id_r[p] <= '0;
            end
        end else begin
            rr_ptr_r    <= alloc_next_ptr_s;
            own_valid_r <= alloc_port_valid_s;
            for (int p = 0; p < PORT_COUNT; p++) begin
                own_id_r[p] <= alloc_port_id_s[p];
            end
        end
    end

    // Steer each granted requester onto its port; idle ports are driven to zero.
    always_comb begin
        ram_address   = '0;
        ram_datain    = '0;
        ram_mem_write = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (alloc_port_valid_s[p] && !reset) begin
                ram_mem_write[p] = req_we[alloc_port_id_s[p]];
                ram_address[slice_lsb(p, ADDR_WIDTH) +: ADDR_WIDTH] =
                    req_addr[slice_lsb(int'(alloc_port_id_s[p]), ADDR_WIDTH) +: ADDR_WIDTH];
                ram_datain[slice_lsb(p, MEM_WIDTH) +: MEM_WIDTH] =
                    req_wdata[slice_lsb(int'(alloc_port_id_s[p]), MEM_WIDTH) +: MEM_WIDTH];
            end else begin
                ram_mem_write[p] = 1'b0;
            end
        end
    end

    // Return each port's registered data to its owner; a response that would
    // land while reset is high is dropped.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (own_valid_r[p] && !reset) begin
                rsp_valid[own_id_r[p]] = 1'b1;
                rsp_data[slice_lsb(int'(own_id_r[p]), MEM_WIDTH) +: MEM_WIDTH] =
                    ram_dataout[slice_lsb(p, MEM_WIDTH) +: MEM_WIDTH];
            end else begin
                rsp_valid = rsp_valid;
            end
        end
    end

endmodule

// File: tb/tb_multiport_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multiport_ram_arbiter
// Directed scenarios followed by randomized traffic. A small RAM with
// registered read data (write returns the written word) sits on the RAM side.
// Expected grants, port usage and responses come from a reference model that
// works on queues of granted requesters and a shadow memory.
// ---------------------------------------------------------------------------
module tb_multiport_ram_arbiter;

    localparam int NR = 4;
    localparam int PC = 2;
    localparam int AW = 12;
    localparam int MW = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*MW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [NR*MW-1:0]  rsp_data;
    logic [PC*AW-1:0]  ram_address;
    logic [PC*MW-1:0]  ram_datain;
    logic [PC-1:0]     ram_mem_write;
    logic [PC*MW-1:0]  ram_dataout;

    always #5 clk = ~clk;

    multiport_ram_arbiter #(
        .NUM_REQ(NR), .PORT_COUNT(PC), .ADDR_WIDTH(AW), .MEM_WIDTH(MW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_address(ram_address), .ram_datain(ram_datain),
        .ram_mem_write(ram_mem_write), .ram_dataout(ram_dataout)
    );

    // RAM with registered read data; a write reads back the written word.
    logic [MW-1:0] mem  [4096];
    logic [MW-1:0] dout [PC];
    always @(posedge clk) begin
        for (int p = 0; p < PC; p++) begin
            if (ram_mem_write[p]) begin
                mem[ram_address[p*AW +: AW]] <= ram_datain[p*MW +: MW];
                dout[p] <= ram_datain[p*MW +: MW];
            end else begin
                dout[p] <= mem[ram_address[p*AW +: AW]];
            end
        end
    end
    always_comb begin
        ram_dataout = '0;
        for (int p = 0; p < PC; p++) ram_dataout[p*MW +: MW] = dout[p];
    end

    // Reference model state
    int            n_cmp = 0;
    int            n_bad = 0;
    int            model_ptr = 0;
    logic [MW-1:0] gmem [4096];
    logic [NR-1:0] exp_rv = '0;
    logic [MW-1:0] exp_rd [NR];
    logic [NR-1:0] granted;
    logic [NR-1:0] obs_ready;
    logic [NR-1:0] obs_rv;
    logic [NR*MW-1:0] obs_rd;
    int            grant_cnt [NR];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [MW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*MW +: MW] = d;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
        req_we[i] = 1'b0;
        req_addr[i*AW +: AW] = '0;
        req_wdata[i*MW +: MW] = '0;
    endtask

    // One clock cycle: predict, compare at the falling edge, advance the model.
    task automatic step();
        int            gq[$];
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] nxt_rv;
        logic [MW-1:0] nxt_rd [NR];
        @(negedge clk);
        gq.delete();
        if (!reset) begin
            for (int k = 0; k < NR; k++) begin
                int   i;
                logic hz;
                i = (model_ptr + k) % NR;
                if (req_valid[i] && gq.size() < PC) begin
                    hz = 1'b0;
                    foreach (gq[j]) begin
                        if (req_addr[gq[j]*AW +: AW] == req_addr[i*AW +: AW] && (req_we[i] || req_we[gq[j]]))
                            hz = 1'b1;
                    end
                    if (!hz) gq.push_back(i);
                end
            end
        end
        exp_ready = '0;
        foreach (gq[j]) exp_ready[gq[j]] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), reset ? 64'(0) : 64'(exp_rv));
        for (int i = 0; i < NR; i++)
            check("rsp_data", 64'(rsp_data[i*MW +: MW]), (!reset && exp_rv[i]) ? 64'(exp_rd[i]) : 64'(0));
        for (int p = 0; p < PC; p++) begin
            logic [AW-1:0] ea;
            logic          ew;
            logic [MW-1:0] ed;
            ea = '0; ew = 1'b0; ed = '0;
            if (p < gq.size()) begin
                ea = req_addr[gq[p]*AW +: AW];
                ew = req_we[gq[p]];
                ed = req_wdata[gq[p]*MW +: MW];
            end
            check("ram_mem_write", 64'(ram_mem_write[p]), 64'(ew));
            check("ram_address", 64'(ram_address[p*AW +: AW]), 64'(ea));
            if (ew || p >= gq.size()) check("ram_datain", 64'(ram_datain[p*MW +: MW]), 64'(ed));
        end
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_rd    = rsp_data;
        nxt_rv = '0;
        for (int i = 0; i < NR; i++) nxt_rd[i] = '0;
        foreach (gq[j]) begin
            nxt_rv[gq[j]] = 1'b1;
            nxt_rd[gq[j]] = req_we[gq[j]] ? req_wdata[gq[j]*MW +: MW] : gmem[req_addr[gq[j]*AW +: AW]];
            grant_cnt[gq[j]]++;
        end
        foreach (gq[j]) if (req_we[gq[j]]) gmem[req_addr[gq[j]*AW +: AW]] = req_wdata[gq[j]*MW +: MW];
        exp_rv = nxt_rv;
        exp_rd = nxt_rd;
        if (reset) model_ptr = 0;
        else if (gq.size() > 0) model_ptr = (gq[gq.size()-1] + 1) % NR;
        granted = exp_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [MW-1:0] d);
        int n;
        set_req(0, 1'b1, a, d);
        n = 0;
        do begin
            step();
            n++;
        end while (!granted[0] && n < 8);
        check("write_granted", 64'(granted[0]), 64'(1));
        clr_req(0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < NR; i++) begin exp_rd[i] = '0; grant_cnt[i] = 0; end
        for (int a = 0; a < 4096; a++) gmem[a] = '0;
        step();
        check("reset_ready", 64'(obs_ready), 64'(0));
        check("reset_rsp_valid", 64'(obs_rv), 64'(0));
        step();
        reset = 1'b0;

        // Preload through the arbiter itself.
        write_word(12'h010, 12'h5A5);
        write_word(12'h030, 12'h111);
        for (int a = 0; a < 8; a++) write_word(AW'(12'h100 + a), MW'(a * 12'h111));

        // Idle, then a single read from requester 2.
        do_reset();
        step();
        step();
        set_req(2, 1'b0, 12'h010, 12'h000);
        step();
        check("t1_ready", 64'(obs_ready), 64'(4'b0100));
        clr_req(2);
        step();
        check("t1_rsp_valid", 64'(obs_rv), 64'(4'b0100));
        check("t1_rsp_data", 64'(obs_rd[2*MW +: MW]), 64'(12'h5A5));

        // Full contention from rr_ptr = 0.
        do_reset();
        for (int i = 0; i < NR; i++) grant_cnt[i] = 0;
        set_req(0, 1'b0, 12'h010, 12'h000);
        set_req(1, 1'b0, 12'h030, 12'h000);
        set_req(2, 1'b0, 12'h100, 12'h000);
        set_req(3, 1'b0, 12'h101, 12'h000);
        for (int c = 0; c < 6; c++) begin
            step();
            check("t2_ready", 64'(obs_ready), (c % 2 == 0) ? 64'(4'b0011) : 64'(4'b1100));
        end
        for (int i = 0; i < NR; i++) check("t2_grant_count", 64'(grant_cnt[i]), 64'(3));
        for (int i = 0; i < NR; i++) clr_req(i);
        step();

        // Write/read hazard on the same address.
        do_reset();
        set_req(0, 1'b1, 12'h020, 12'hABC);
        set_req(1, 1'b0, 12'h020, 12'h000);
        step();
        check("t3_ready_first", 64'(obs_ready), 64'(4'b0001));
        clr_req(0);
        step();
        check("t3_ready_second", 64'(obs_ready), 64'(4'b0010));
        clr_req(1);
        step();
        check("t3_rsp_valid", 64'(obs_rv), 64'(4'b0010));
        check("t3_rsp_data", 64'(obs_rd[1*MW +: MW]), 64'(12'hABC));

        // Two reads share an address in the same cycle.
        do_reset();
        set_req(1, 1'b0, 12'h030, 12'h000);
        set_req(3, 1'b0, 12'h030, 12'h000);
        step();
        check("t4_ready", 64'(obs_ready), 64'(4'b1010));
        clr_req(1);
        clr_req(3);
        step();
        check("t4_rsp_valid", 64'(obs_rv), 64'(4'b1010));
        check("t4_rsp_data1", 64'(obs_rd[1*MW +: MW]), 64'(12'h111));
        check("t4_rsp_data3", 64'(obs_rd[3*MW +: MW]), 64'(12'h111));

        // Reset right after a granted write.
        do_reset();
        set_req(0, 1'b1, 12'h040, 12'h777);
        step();
        check("t5_ready", 64'(obs_ready), 64'(4'b0001));
        clr_req(0);
        reset = 1'b1;
        step();
        check("t5_rsp_dropped", 64'(obs_rv), 64'(0));
        reset = 1'b0;
        set_req(0, 1'b0, 12'h040, 12'h000);
        set_req(1, 1'b0, 12'h010, 12'h000);
        set_req(2, 1'b0, 12'h030, 12'h000);
        set_req(3, 1'b0, 12'h100, 12'h000);
        step();
        check("t5_restart", 64'(obs_ready), 64'(4'b0011));
        step();
        check("t5_rsp_valid", 64'(obs_rv), 64'(4'b0011));
        check("t5_rsp_data", 64'(obs_rd[0*MW +: MW]), 64'(12'h777));
        for (int i = 0; i < NR; i++) clr_req(i);
        step();

        // Randomized traffic on a small address window to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (granted[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_req(i, 1'($urandom_range(0, 1)), AW'(12'h100 + $urandom_range(0, 7)),
                                MW'($urandom_range(0, 4095)));
                    else
                        clr_req(i);
                end
            end
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;
        for (int i = 0; i < NR; i++) clr_req(i);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multiport_ram_arbiter.md
Name: multiport_ram_arbiter

Overview:
- Shares the PORT_COUNT physical ports of the multiport dynamic RAM between NUM_REQ independent requesters (fetch, load/store, DMA, debug).
- Each cycle it allocates up to PORT_COUNT pending requests using round-robin priority.
- It drives the RAM's packed address, data and write-enable buses, then routes each port's registered read data back to the requester that owns it.
- It prevents same-cycle, same-address write conflicts, so the RAM's port ordering is never architecturally visible.

Parameters:
- NUM_REQ, 4, number of requesters (>= PORT_COUNT).
- PORT_COUNT, 2, number of RAM ports.
- ADDR_WIDTH, 12, RAM address width.
- MEM_WIDTH, 12, RAM word width.

Ports:
- clk  in  1  Single clock; all state updates on rising edge.
- reset  in  1  Synchronous, active-high reset.
- req_valid  in  NUM_REQ  Request pending, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  Packed addresses; requester i occupies slice [(i+1)*ADDR_WIDTH-1 -: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*MEM_WIDTH  Packed write data, same slicing rule.
- req_ready  out  NUM_REQ  Grant; the request is accepted this cycle.
- rsp_valid  out  NUM_REQ  Response valid for requester i.
- rsp_data  out  NUM_REQ*MEM_WIDTH  Packed response data.
- ram_address  out  PORT_COUNT*ADDR_WIDTH  To RAM address.
- ram_datain  out  PORT_COUNT*MEM_WIDTH  To RAM datain.
- ram_mem_write  out  PORT_COUNT  To RAM mem_write.
- ram_dataout  in  PORT_COUNT*MEM_WIDTH  From RAM dataout (registered inside the RAM).

Behaviour:
- Handshake:
  - A requester holds req_valid, req_we, req_addr and req_wdata stable until req_ready is sampled high.
  - req_ready is combinational from the current inputs and state; it never asserts without req_valid.
- Allocation:
  - Scan starts at rr_ptr and wraps modulo NUM_REQ.
  - The first eligible requester in scan order takes port 0, the next takes port 1, and so on, up to PORT_COUNT grants.
- Hazard rule:
  - A requester is ineligible if its address equals that of a requester already granted earlier in the same scan, and either of the two is a write.
  - An ineligible requester stays pending and is retried next cycle.
  - Multiple reads to the same address may be granted together.
- rr_ptr update:
  - If any grant occurs, rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - If no grant occurs, rr_ptr is unchanged.
- Unused ports: ram_mem_write bit = 0, ram_address slice = 0, ram_datain slice = 0.
- Response path:
  - Registered map per port: own_valid[p], own_id[p], captured at the edge ending the grant cycle.
  - In the cycle after a grant, rsp_valid[own_id[p]] = 1 and rsp_data slice = ram_dataout slice p.
  - Reads return memory contents. Writes return the written word; the RAM reads back after the write, and this serves as the write acknowledgement.
  - Latency: exactly 1 cycle from req_ready to rsp_valid.
  - rsp_data slices with rsp_valid low are driven to 0.
- Back-to-back operation:
  - A requester may be granted on consecutive cycles, giving one response per cycle.
  - A read granted the cycle after a write to the same address returns the new data.
- Reset (while reset is high):
  - req_ready = 0, ram_mem_write = 0, and rsp_valid = 0 the following cycle.
  - rr_ptr <= 0 and own_valid <= 0.
  - An in-flight response from the cycle before reset is dropped.
  - The first grants occur in the first cycle with reset low.
- Edge cases:
  - NUM_REQ == PORT_COUNT with all requesters valid and no hazards: every requester is granted every cycle.
  - All requesters idle: no RAM writes occur and rr_ptr holds.

Decomposition:
- Shared package holds:
  - default widths ADDR_WIDTH = 12, MEM_WIDTH = 12, PORT_COUNT = 2;
  - a packed-slice index helper function used by the RAM and by this block.
- One sub-module, rr_port_allocator: purely combinational. It takes req_valid, req_we, req_addr and rr_ptr, and produces the grant vector, per-port ids and valids, and next_ptr.
- The top level holds rr_ptr, the ownership registers, RAM bus muxing and response demux.

Test Plan:
- Idle then a single read: reset released, mem[0x010] = 0x5A5, req 2 reads 0x010 -> req_ready[2] in that cycle; next cycle rsp_valid[2] = 1, rsp_data[2] = 0x5A5, port 0 used.
- Full contention: all 4 requesters read distinct addresses continuously from rr_ptr = 0 -> grants {0,1}, {2,3}, {0,1}, ...; each requester gets one response every 2 cycles.
- Write hazard: req 0 writes 0x020 = 0xABC and req 1 reads 0x020 in the same cycle -> only req 0 granted; req 1 granted next cycle and receives 0xABC.
- Shared read: req 1 and req 3 both read 0x030 (= 0x111) -> both granted in the same cycle; both rsp_data = 0x111.
- Reset mid-operation: grant req 0 write, assert reset in the next cycle -> rsp_valid stays 0; the write commits only if the RAM sampled it before reset; rr_ptr = 0 and arbitration restarts at req 0 after release.
